tc_ps_gp_rd_ctrl: RTL and testbench
===================================

# tc_ps_gp_rd_ctrl

PS GP0 register-read controller. It accepts single read requests from the PS GP0 slave interface, splits the address into region (high) and register offset (low) fields, and dispatches the read to exactly one region slave (GLOBAL, CAPTURE, LASER, BUS, OTHER) over a req/ack handshake. It returns the read data with a one-cycle valid strobe and flags decode errors and timeouts. It sits between the GP0 AXI-lite shim and the per-region register banks.

## Interface
- WTH_ADDR, 32, full GP address width
- WTH_ADDL, 10, register-offset width (low field); high field = WTH_ADDR-WTH_ADDL
- WTH_DATA, 32, read data width
- N_REGION, 5, number of region slaves; region index = addr high field
- TIMEOUT_CYC, 255, max cycles waiting for slv_ack (1..65535)
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on error
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- rden  in  1  read request strobe, sampled only when rd_busy=0
- addr  in  WTH_ADDR  read address, valid with rden
- rd_busy  out  1  high while a read is outstanding
- rd_drop  out  1  one-cycle pulse: rden arrived while rd_busy=1 (request discarded)
- rdata  out  WTH_DATA  read data, valid when rvalid=1, held until next completion
- rvalid  out  1  one-cycle completion strobe
- rerr  out  1  qualifies rvalid: decode error or timeout
- slv_req  out  N_REGION  one-hot request, held until ack or abort
- slv_addr  out  WTH_ADDL  register offset to slaves, stable while slv_req≠0
- slv_ack  in  N_REGION  per-region acknowledge, one cycle, data valid same cycle
- slv_rdata  in  N_REGION*WTH_DATA  packed per-region read data, region i at [i*WTH_DATA +: WTH_DATA]

## Operation
- FSM: IDLE, REQ, DONE, ERR.
- IDLE: if rden=1, register addr. If the high field is < N_REGION, go to REQ. Otherwise go to ERR (decode error).
- REQ: drive slv_req one-hot for the registered region and slv_addr = low field. Ack from the selected region captures its data and moves to DONE. Acks from unselected regions are ignored.
- DONE: rvalid=1, rerr=0, return to IDLE.
- ERR: rvalid=1, rerr=1, rdata=ERR_DATA, return to IDLE.
- rden is ignored unless the FSM is in IDLE. In REQ/DONE/ERR, rden pulses rd_drop and is discarded.
- Timeout: the counter clears on entering REQ and increments each REQ cycle. When the count reaches TIMEOUT_CYC with no ack, drop slv_req and go to ERR.
- Ack in the same cycle as the timeout: the ack wins, go to DONE.
- Reset (any time, including mid-REQ): FSM to IDLE and all outputs 0 (rdata=0, slv_req=0, slv_addr=0). The slave sees its req fall and must abandon the transaction.

## Timing
- rden sampled at edge 0. slv_req is high from edge 0 until the edge that samples ack.
- Ack present in the first REQ cycle: rvalid high in the cycle after edge 1. Minimum latency is 2 edges from rden to rvalid.
- Decode error: rvalid/rerr high one cycle after the rden edge.
- Timeout: rvalid/rerr high after TIMEOUT_CYC REQ cycles + 1.
- rd_busy = (state≠IDLE), registered. rd_busy deasserts in the cycle after rvalid, so back-to-back reads issue at one per (latency+1) cycles.
- rd_drop is registered, asserted the cycle after the offending rden.

## Configuration
- TC_GP_RD_TIMEOUT_EN defined: timeout counter present, behaviour as above.
- TC_GP_RD_TIMEOUT_EN undefined: no counter. REQ waits indefinitely for ack, rerr is only raised by decode errors, and TIMEOUT_CYC is unused.

## Structure
- Package tc_ps_gp_pkg holds the following, shared with the region register banks:
  - region localparams ADDH_GLOBAL=0, ADDH_CAPTURE=1, ADDH_LASER=2, ADDH_BUS=3, ADDH_OTHER=4
  - WTH_ADDR/WTH_ADDL defaults
  - ERR_DATA
  - FSM state encoding
- Sub-module tc_ps_gp_addr_dec: splits addr into high and low fields and produces the one-hot region select plus a decode-error flag. Used here and by the write-path controller.

## Test plan
- rden with addr=0x0000_0C04 (BUS, offset 4), slv_ack[3] on the first REQ cycle with data 0x1234_5678 -> slv_req=5'b01000, slv_addr=4, rvalid at edge 2, rdata=0x1234_5678, rerr=0.
- rden with addr=0x0000_1C00 (high=7) -> no slv_req, rvalid+rerr one cycle later, rdata=0xDEAD_BEEF.
- With TC_GP_RD_TIMEOUT_EN and TIMEOUT_CYC=8, CAPTURE read with no ack -> slv_req drops after 8 cycles, then rvalid+rerr with ERR_DATA. Same case with ack on cycle 8 -> rvalid, rerr=0.
- A LASER read is outstanding and rden is pulsed again -> rd_drop pulses once, the second request is never issued, and the first completes normally. slv_ack[0] asserted during the LASER read is ignored.
- rst asserted while slv_req[1]=1 -> all outputs 0 asynchronously. After release, a new GLOBAL read completes normally.

Source files
------------

// File: rtl/tc_ps_gp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tc_ps_gp_pkg
// Purpose  : Shared definitions for the PS GP0 register path: region indices
//            (address high field), default address/data widths, the read
//            error pattern and the read-controller state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tc_ps_gp_pkg;

    // Region index = GP address high field
    localparam int ADDH_GLOBAL  = 0;
    localparam int ADDH_CAPTURE = 1;
    localparam int ADDH_LASER   = 2;
    localparam int ADDH_BUS     = 3;
    localparam int ADDH_OTHER   = 4;

    // Default widths
    localparam int c_wth_addr_dflt = 32;
    localparam int c_wth_addl_dflt = 10;
    localparam int c_wth_data_dflt = 32;
    localparam int c_n_region_dflt = ADDH_OTHER + 1;

    // Data returned on decode error or timeout
    localparam logic [31:0] c_err_data = 32'hDEAD_BEEF;

    // Read-controller state encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;
    localparam logic [1:0] c_st_err  = 2'd3;

endpackage : tc_ps_gp_pkg
`default_nettype wire

// File: rtl/tc_ps_gp_addr_dec.sv
`default_nettype none
// ============================================================================
// Module   : tc_ps_gp_addr_dec
// Purpose  : Splits a GP address into region (high) and register offset (low)
//            fields; produces a one-hot region select and a decode-error flag
//            when the high field does not name an existing region.
// Ports    : addr       - full GP address
//            addr_l     - register offset (low field)
//            region_sel - one-hot region select (all zero on decode error)
//            dec_err    - high field >= N_REGION
// Revision : 1.0 - initial release
// ============================================================================
module tc_ps_gp_addr_dec
    import tc_ps_gp_pkg::*;
#(
    parameter int WTH_ADDR = c_wth_addr_dflt,
    parameter int WTH_ADDL = c_wth_addl_dflt,
    parameter int N_REGION = c_n_region_dflt
) (
    input  logic [WTH_ADDR-1:0] addr,
    output logic [WTH_ADDL-1:0] addr_l,
    output logic [N_REGION-1:0] region_sel,
    output logic                dec_err
);

    localparam int c_wth_addh = WTH_ADDR - WTH_ADDL;

    logic [c_wth_addh-1:0] w_addr_h;

    assign w_addr_h = addr[WTH_ADDR-1:WTH_ADDL];
    assign addr_l   = addr[WTH_ADDL-1:0];

    // Full-width compare per region so any set upper bit yields no match.
    for (genvar gi = 0; gi < N_REGION; gi++) begin : g_sel
        assign region_sel[gi] = (w_addr_h == c_wth_addh'(gi));
    end

    assign dec_err = ~|region_sel;

endmodule : tc_ps_gp_addr_dec
`default_nettype wire

// File: rtl/tc_ps_gp_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tc_ps_gp_rd_ctrl
// Purpose  : PS GP0 register-read controller. Accepts single reads, dispatches
//            each to one region slave over a req/ack handshake and returns the
//            data with a one-cycle rvalid strobe; flags decode errors and
//            (optionally) slave timeouts via rerr.
// Config   : TC_GP_RD_TIMEOUT_EN - when defined, a REQ that sees no ack for
//            TIMEOUT_CYC cycles is aborted with an error completion. When
//            undefined, REQ waits indefinitely for ack.
// Ports    : clk, rst (async, active-low)
//            rden/addr           - read request (taken only when idle)
//            rd_busy             - read outstanding
//            rd_drop             - request discarded because busy
//            rdata/rvalid/rerr   - completion
//            slv_req/slv_addr    - one-hot request + offset to region slaves
//            slv_ack/slv_rdata   - per-region acknowledge and packed data
// Revision : 1.0 - initial release
// ============================================================================
module tc_ps_gp_rd_ctrl
    import tc_ps_gp_pkg::*;
#(
    parameter int                  WTH_ADDR    = c_wth_addr_dflt,
    parameter int                  WTH_ADDL    = c_wth_addl_dflt,
    parameter int                  WTH_DATA    = c_wth_data_dflt,
    parameter int                  N_REGION    = c_n_region_dflt,
    parameter int                  TIMEOUT_CYC = 255,
    parameter logic [WTH_DATA-1:0] ERR_DATA    = c_err_data
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rden,
    input  logic [WTH_ADDR-1:0]          addr,
    output logic                         rd_busy,
    output logic                         rd_drop,
    output logic [WTH_DATA-1:0]          rdata,
    output logic                         rvalid,
    output logic                         rerr,
    output logic [N_REGION-1:0]          slv_req,
    output logic [WTH_ADDL-1:0]          slv_addr,
    input  logic [N_REGION-1:0]          slv_ack,
    input  logic [N_REGION*WTH_DATA-1:0] slv_rdata
);

    // TIMEOUT_CYC must fit the 16-bit wait counter.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("tc_ps_gp_rd_ctrl: TIMEOUT_CYC out of range 1..65535");
    end

    logic [1:0]          r_state;
    logic                r_rd_busy;
    logic                r_rd_drop;
    logic [WTH_DATA-1:0] r_rdata;
    logic                r_rvalid;
    logic                r_rerr;
    logic [N_REGION-1:0] r_slv_req;
    logic [WTH_ADDL-1:0] r_slv_addr;

    logic [WTH_ADDL-1:0] w_addr_l;
    logic [N_REGION-1:0] w_region_sel;
    logic                w_dec_err;
    logic                w_ack;
    logic [WTH_DATA-1:0] w_ack_data;
    logic                w_timeout;

    tc_ps_gp_addr_dec #(
        .WTH_ADDR (WTH_ADDR),
        .WTH_ADDL (WTH_ADDL),
        .N_REGION (N_REGION)
    ) u_addr_dec (
        .addr       (addr),
        .addr_l     (w_addr_l),
        .region_sel (w_region_sel),
        .dec_err    (w_dec_err)
    );

    // Only the region currently requested may complete the transaction;
    // acks on other lanes are masked off here.
    assign w_ack = |(slv_ack & r_slv_req);

    // AND-OR data mux keyed by the registered one-hot request.
    always_comb begin
        w_ack_data = '0;
        for (int i = 0; i < N_REGION; i++) begin
            if (r_slv_req[i]) begin
                w_ack_data = w_ack_data | slv_rdata[i*WTH_DATA +: WTH_DATA];
            end
        end
    end

`ifdef TC_GP_RD_TIMEOUT_EN
    logic [15:0] r_cnt;

    // Counter holds the number of completed REQ cycles; it is zero in every
    // other state, so it is always clear when REQ is entered. Timeout fires on
    // the edge that ends the TIMEOUT_CYC-th REQ cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == c_st_req && !w_ack && !w_timeout) begin
            r_cnt <= r_cnt + 16'd1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == c_st_req) && (r_cnt == 16'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_st_idle;
            r_rd_busy  <= 1'b0;
            r_rd_drop  <= 1'b0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_rerr     <= 1'b0;
            r_slv_req  <= '0;
            r_slv_addr <= '0;
        end else begin
            // Any rden outside IDLE is discarded and reported one cycle later.
            r_rd_drop <= rden && (r_state != c_st_idle);

            case (r_state)
                c_st_idle: begin
                    if (rden) begin
                        r_rd_busy <= 1'b1;
                        if (w_dec_err) begin
                            r_state  <= c_st_err;
                            r_rvalid <= 1'b1;
                            r_rerr   <= 1'b1;
                            r_rdata  <= ERR_DATA;
                        end else begin
                            r_state    <= c_st_req;
                            r_slv_req  <= w_region_sel;
                            r_slv_addr <= w_addr_l;
                        end
                    end
                end

                c_st_req: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (w_ack) begin
                        r_state   <= c_st_done;
                        r_slv_req <= '0;
                        r_rvalid  <= 1'b1;
                        r_rerr    <= 1'b0;
                        r_rdata   <= w_ack_data;
                    end else if (w_timeout) begin
                        r_state   <= c_st_err;
                        r_slv_req <= '0;
                        r_rvalid  <= 1'b1;
                        r_rerr    <= 1'b1;
                        r_rdata   <= ERR_DATA;
                    end
                end

                c_st_done, c_st_err: begin
                    r_state   <= c_st_idle;
                    r_rd_busy <= 1'b0;
                    r_rvalid  <= 1'b0;
                    r_rerr    <= 1'b0;
                end

                default: begin
                    r_state   <= c_st_idle;
                    r_rd_busy <= 1'b0;
                    r_rvalid  <= 1'b0;
                    r_rerr    <= 1'b0;
                    r_slv_req <= '0;
                end
            endcase
        end
    end

    assign rd_busy  = r_rd_busy;
    assign rd_drop  = r_rd_drop;
    assign rdata    = r_rdata;
    assign rvalid   = r_rvalid;
    assign rerr     = r_rerr;
    assign slv_req  = r_slv_req;
    assign slv_addr = r_slv_addr;

endmodule : tc_ps_gp_rd_ctrl
`default_nettype wire

// File: tb/tb_tc_ps_gp_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tc_ps_gp_rd_ctrl
// Purpose  : Self-checking bench for tc_ps_gp_rd_ctrl. Each read is described
//            as a transaction (address, ack cycle, data, drop cycle) and its
//            expected cycle-by-cycle behaviour is derived from the read rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tc_ps_gp_rd_ctrl;

    localparam int c_to = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         rden;
    logic [31:0]  addr;
    logic         rd_busy;
    logic         rd_drop;
    logic [31:0]  rdata;
    logic         rvalid;
    logic         rerr;
    logic [4:0]   slv_req;
    logic [9:0]   slv_addr;
    logic [4:0]   slv_ack;
    logic [159:0] slv_rdata;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tc_ps_gp_rd_ctrl #(
        .WTH_ADDR    (32),
        .WTH_ADDL    (10),
        .WTH_DATA    (32),
        .N_REGION    (5),
        .TIMEOUT_CYC (c_to),
        .ERR_DATA    (32'hDEAD_BEEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rden      (rden),
        .addr      (addr),
        .rd_busy   (rd_busy),
        .rd_drop   (rd_drop),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rerr      (rerr),
        .slv_req   (slv_req),
        .slv_addr  (slv_addr),
        .slv_ack   (slv_ack),
        .slv_rdata (slv_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One read transaction. ack_at: REQ cycle (1-based) on which the selected
    // slave acks, 0 = never. drop_at: busy cycle on which a second rden is
    // pulsed, 0 = none. stray: ack unselected regions while busy.
    task automatic do_read(input logic [31:0] a, input int ack_at, input logic [31:0] d,
                           input int drop_at, input bit stray);
        int          reg_i;
        bit          bad;
        int          n_req;
        bit          exp_err;
        logic [31:0] exp_data;
        logic [4:0]  onehot;
        bit          drop_pend;

        reg_i = 0;
        bad   = (a[31:10] >= 22'd5);
        if (!bad) reg_i = int'(a[12:10]);
        onehot = bad ? 5'd0 : 5'(1 << reg_i);

        if (bad) begin
            n_req   = 0;
            exp_err = 1'b1;
        end else begin
`ifdef TC_GP_RD_TIMEOUT_EN
            if (ack_at == 0 || ack_at > c_to) begin
                n_req   = c_to;
                exp_err = 1'b1;
            end else begin
                n_req   = ack_at;
                exp_err = 1'b0;
            end
`else
            n_req   = ack_at;
            exp_err = 1'b0;
`endif
        end
        exp_data = exp_err ? 32'hDEAD_BEEF : d;

        @(negedge clk);
        chk("idle_busy", 64'(rd_busy), 64'd0);
        rden = 1'b1;
        addr = a;
        @(negedge clk);
        rden      = 1'b0;
        drop_pend = 1'b0;

        for (int c = 1; c <= n_req + 1; c++) begin
            chk("rd_drop", 64'(rd_drop), 64'(drop_pend));
            chk("busy", 64'(rd_busy), 64'd1);
            if (c <= n_req) begin
                chk("slv_req", 64'(slv_req), 64'(onehot));
                chk("slv_addr", 64'(slv_addr), 64'(a[9:0]));
                chk("rvalid_req", 64'(rvalid), 64'd0);
            end else begin
                chk("rvalid", 64'(rvalid), 64'd1);
                chk("rerr", 64'(rerr), 64'(exp_err));
                chk("rdata", 64'(rdata), 64'(exp_data));
                chk("slv_req_done", 64'(slv_req), 64'd0);
            end
            for (int l = 0; l < 5; l++) slv_rdata[l*32 +: 32] = $urandom;
            slv_ack = stray ? ((5'($urandom) | 5'b00001) & ~onehot) : 5'd0;
            if (c == ack_at && c <= n_req) begin
                slv_ack = slv_ack | onehot;
                slv_rdata[reg_i*32 +: 32] = d;
            end
            drop_pend = (c == drop_at);
            rden      = drop_pend;
            if (drop_pend) addr = $urandom;
            @(negedge clk);
            slv_ack = 5'd0;
            rden    = 1'b0;
        end

        chk("rd_drop_end", 64'(rd_drop), 64'(drop_pend));
        chk("rvalid_end", 64'(rvalid), 64'd0);
        chk("busy_end", 64'(rd_busy), 64'd0);
        chk("slv_req_end", 64'(slv_req), 64'd0);
        chk("rdata_hold", 64'(rdata), 64'(exp_data));
    endtask

    initial begin
        logic [31:0] a;
        int          ack_at;
        int          region;

        rst       = 1'b0;
        rden      = 1'b0;
        addr      = '0;
        slv_ack   = '0;
        slv_rdata = '0;
        #12;
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_busy", 64'(rd_busy), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_req", 64'(slv_req), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // BUS offset 4, ack on first REQ cycle
        do_read(32'h0000_0C04, 1, 32'h1234_5678, 0, 1'b0);
        // Decode error (high field 7)
        do_read(32'h0000_1C00, 0, 32'h0, 0, 1'b0);
`ifdef TC_GP_RD_TIMEOUT_EN
        // CAPTURE with no ack -> timeout
        do_read(32'h0000_0408, 0, 32'h0, 0, 1'b1);
`endif
        // CAPTURE acked on the last allowed cycle
        do_read(32'h0000_0408, c_to, 32'hA5A5_0001, 0, 1'b0);
        // LASER with a dropped second rden and stray acks incl. region 0
        do_read(32'h0000_0823, 3, 32'hCAFE_0002, 2, 1'b1);
        // Drop during the completion cycle
        do_read(32'h0000_1010, 2, 32'h0BAD_F00D, 3, 1'b0);

        // Reset while CAPTURE request is outstanding
        @(negedge clk);
        rden = 1'b1;
        addr = 32'h0000_0400;
        @(negedge clk);
        rden = 1'b0;
        chk("pre_rst_req", 64'(slv_req), 64'b00010);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_req", 64'(slv_req), 64'd0);
        chk("arst_busy", 64'(rd_busy), 64'd0);
        chk("arst_addr", 64'(slv_addr), 64'd0);
        chk("arst_rdata", 64'(rdata), 64'd0);
        chk("arst_rvalid", 64'(rvalid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        do_read(32'h0000_0010, 2, 32'h600D_0003, 0, 1'b0);

        // Randomized transactions
        for (int k = 0; k < 40; k++) begin
            region = $urandom_range(0, 7);
            a = {22'(region), 10'($urandom_range(0, 1023))};
            if ($urandom_range(0, 7) == 0) a[31:10] = 22'($urandom);
`ifdef TC_GP_RD_TIMEOUT_EN
            ack_at = $urandom_range(0, c_to + 2);
`else
            ack_at = $urandom_range(1, c_to + 2);
`endif
            do_read(a, ack_at, $urandom, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule : tb_tc_ps_gp_rd_ctrl
`default_nettype wire
